// File: rtl/dmem_port.sv
// Core-side initiator for the shared data-RAM arbiter: turns a one-cycle ld/st strobe
// into a held rden/wren request and returns a done pulse. Optional timeout: DMEM_TIMEOUT_EN.
module dmem_port #(
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       ld,
    input  logic       st,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       err,
    output logic       rden,
    output logic       wren,
    output logic [7:0] Address,
    output logic [7:0] Din,
    input  logic       acq,
    input  logic [7:0] Dq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RDWAIT
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

    state_t     state_q, state_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rden_q, rden_d;
    logic       wren_q, wren_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] din_q, din_d;
    logic [2:0] lat_q, lat_d;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic       err_q, err_d;
    logic [7:0] tmo_q, tmo_d;
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            rden_q  <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            lat_q   <= '0;
`ifdef DMEM_TIMEOUT_EN
            err_q   <= 1'b0;
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            rden_q  <= rden_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            lat_q   <= lat_d;
`ifdef DMEM_TIMEOUT_EN
            err_q   <= err_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        rden_d  = rden_q;
        wren_d  = wren_q;
        addr_d  = addr_q;
        din_d   = din_q;
        lat_d   = lat_q;
`ifdef DMEM_TIMEOUT_EN
        err_d   = 1'b0;
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // st has priority; a simultaneous ld is dropped
                if (st) begin
                    addr_d  = addr;
                    din_d   = wdata;
                    wren_d  = 1'b1;
                    state_d = S_REQ;
`ifdef DMEM_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else if (ld) begin
                    addr_d  = addr;
                    rden_d  = 1'b1;
                    state_d = S_REQ;
`ifdef DMEM_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_REQ: begin
                if (acq) begin
                    rden_d = 1'b0;
                    wren_d = 1'b0;
                    if (wren_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        lat_d   = LAT_INIT;
                        state_d = S_RDWAIT;
                    end
                end
`ifdef DMEM_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    rden_d  = 1'b0;
                    wren_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            S_RDWAIT: begin
                if (lat_q == '0) begin
                    rdata_d = Dq;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered busy mirrors the next state so it is low in the done cycle
    assign busy_d  = (state_d != S_IDLE);

    assign busy    = busy_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign rden    = rden_q;
    assign wren    = wren_q;
    assign Address = addr_q;
    assign Din     = din_q;
`ifdef DMEM_TIMEOUT_EN
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_port.sv
// Directed self-checking bench for dmem_port: one instance at RD_LAT=1, one at RD_LAT=3.
module tb_dmem_port;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       ld, st, acq;
    logic [7:0] addr, wdata, Dq;
    logic       busy, done, err, rden, wren;
    logic [7:0] rdata, Address, Din;

    logic       ld3, st3, acq3;
    logic       busy3, done3, err3, rden3, wren3;
    logic [7:0] rdata3, Address3, Din3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    dmem_port #(.RD_LAT(1), .TIMEOUT(4)) u_dut (
        .CLK(CLK), .rst_n(rst_n), .ld(ld), .st(st), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .err(err), .rden(rden), .wren(wren),
        .Address(Address), .Din(Din), .acq(acq), .Dq(Dq)
    );

    dmem_port #(.RD_LAT(3), .TIMEOUT(4)) u_dut3 (
        .CLK(CLK), .rst_n(rst_n), .ld(ld3), .st(st3), .addr(addr), .wdata(wdata),
        .busy(busy3), .done(done3), .rdata(rdata3), .err(err3), .rden(rden3), .wren(wren3),
        .Address(Address3), .Din(Din3), .acq(acq3), .Dq(Dq)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ld = 0; st = 0; acq = 0; addr = '0; wdata = '0; Dq = '0;
        ld3 = 0; st3 = 0; acq3 = 0;
        tick();
        tick();
        n_checks++;
        if ({busy, done, err, rden, wren, rdata, Address, Din} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_dut1: got %h expected 0", {busy, done, err, rden, wren, rdata, Address, Din});
        end
        n_checks++;
        if ({busy3, done3, err3, rden3, wren3, rdata3, Address3, Din3} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_dut3: got %h expected 0", {busy3, done3, err3, rden3, wren3, rdata3, Address3, Din3});
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({busy, done, rden, wren} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b expected 0000", {busy, done, rden, wren});
        end
    endtask

    task automatic test_write_immediate();
        st = 1; addr = 8'h12; wdata = 8'hA5;
        tick();
        st = 0; addr = 8'h00; wdata = 8'h00; acq = 1;
        n_checks++;
        if ({busy, wren, rden, done, Address, Din} !== {4'b1100, 8'h12, 8'hA5}) begin
            n_fail++;
            $display("FAIL wr_req: got %h expected %h", {busy, wren, rden, done, Address, Din}, {4'b1100, 8'h12, 8'hA5});
        end
        tick();
        acq = 0;
        n_checks++;
        if ({busy, wren, rden, done} !== 4'b0001) begin
            n_fail++;
            $display("FAIL wr_done: got %b expected 0001", {busy, wren, rden, done});
        end
        tick();
        n_checks++;
        if ({done, Address, Din, rdata} !== {1'b0, 8'h12, 8'hA5, 8'h00}) begin
            n_fail++;
            $display("FAIL wr_idle_retain: got %h expected %h", {done, Address, Din, rdata}, {1'b0, 8'h12, 8'hA5, 8'h00});
        end
    endtask

    task automatic test_read_delayed_grant();
        ld = 1; addr = 8'h40;
        tick();
        ld = 0; addr = 8'hEE;
        for (int unsigned i = 0; i < 4; i++) begin
            n_checks++;
            if ({busy, rden, wren, done, Address} !== {4'b1100, 8'h40}) begin
                n_fail++;
                $display("FAIL rd_req_hold[%0d]: got %h expected %h", i, {busy, rden, wren, done, Address}, {4'b1100, 8'h40});
            end
            if (i == 3) acq = 1;
            tick();
        end
        acq = 0; Dq = 8'h3C;
        n_checks++;
        if ({busy, rden, done, rdata} !== {3'b100, 8'h00}) begin
            n_fail++;
            $display("FAIL rd_granted: got %h expected %h", {busy, rden, done, rdata}, {3'b100, 8'h00});
        end
        tick();
        Dq = 8'h00;
        n_checks++;
        if ({busy, done, rdata} !== {2'b01, 8'h3C}) begin
            n_fail++;
            $display("FAIL rd_capture: got %h expected %h", {busy, done, rdata}, {2'b01, 8'h3C});
        end
        tick();
        n_checks++;
        if ({done, rdata} !== {1'b0, 8'h3C}) begin
            n_fail++;
            $display("FAIL rd_done_pulse: got %h expected %h", {done, rdata}, {1'b0, 8'h3C});
        end
    endtask

    task automatic test_rd_lat3();
        ld3 = 1; addr = 8'h50;
        tick();
        ld3 = 0; acq3 = 1;
        tick();
        acq3 = 0; Dq = 8'h11;
        n_checks++;
        if ({busy3, rden3, done3} !== 3'b100) begin
            n_fail++;
            $display("FAIL lat3_grant: got %b expected 100", {busy3, rden3, done3});
        end
        tick();
        Dq = 8'h22;
        n_checks++;
        if ({busy3, done3, rdata3} !== {2'b10, 8'h00}) begin
            n_fail++;
            $display("FAIL lat3_e1: got %h expected %h", {busy3, done3, rdata3}, {2'b10, 8'h00});
        end
        tick();
        Dq = 8'h33;
        n_checks++;
        if ({busy3, done3, rdata3} !== {2'b10, 8'h00}) begin
            n_fail++;
            $display("FAIL lat3_e2: got %h expected %h", {busy3, done3, rdata3}, {2'b10, 8'h00});
        end
        tick();
        Dq = 8'h44;
        n_checks++;
        if ({busy3, done3, rdata3} !== {2'b01, 8'h33}) begin
            n_fail++;
            $display("FAIL lat3_e3: got %h expected %h", {busy3, done3, rdata3}, {2'b01, 8'h33});
        end
        tick();
        n_checks++;
        if ({done3, rdata3} !== {1'b0, 8'h33}) begin
            n_fail++;
            $display("FAIL lat3_after: got %h expected %h", {done3, rdata3}, {1'b0, 8'h33});
        end
    endtask

    task automatic test_back_to_back();
        ld = 1; st = 1; addr = 8'h05; wdata = 8'h77;
        tick();
        st = 0; ld = 1; addr = 8'h99;
        n_checks++;
        if ({wren, rden, Address, Din} !== {2'b10, 8'h05, 8'h77}) begin
            n_fail++;
            $display("FAIL col_store_first: got %h expected %h", {wren, rden, Address, Din}, {2'b10, 8'h05, 8'h77});
        end
        tick();
        ld = 0; acq = 1;
        n_checks++;
        if ({busy, wren, rden, Address} !== {3'b110, 8'h05}) begin
            n_fail++;
            $display("FAIL col_ld_ignored: got %h expected %h", {busy, wren, rden, Address}, {3'b110, 8'h05});
        end
        tick();
        acq = 0; ld = 1; addr = 8'h06;
        n_checks++;
        if ({busy, done, wren, rdata} !== {3'b010, 8'h3C}) begin
            n_fail++;
            $display("FAIL col_wr_done: got %h expected %h", {busy, done, wren, rdata}, {3'b010, 8'h3C});
        end
        tick();
        ld = 0; acq = 1;
        n_checks++;
        if ({busy, done, rden, Address} !== {3'b101, 8'h06}) begin
            n_fail++;
            $display("FAIL b2b_accept: got %h expected %h", {busy, done, rden, Address}, {3'b101, 8'h06});
        end
        tick();
        acq = 0; Dq = 8'h5A;
        tick();
        n_checks++;
        if ({done, rdata} !== {1'b1, 8'h5A}) begin
            n_fail++;
            $display("FAIL b2b_read: got %h expected %h", {done, rdata}, {1'b1, 8'h5A});
        end
        tick();
    endtask

    task automatic test_reset_mid_rdwait();
        ld3 = 1; ld = 1; addr = 8'h21;
        tick();
        ld3 = 0; ld = 0; acq3 = 1;
        tick();
        acq3 = 0; Dq = 8'hFF;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, err, rden, wren, rdata, Address, Din} !== 29'd0) begin
            n_fail++;
            $display("FAIL rst_mid_req: got %h expected 0", {busy, done, err, rden, wren, rdata, Address, Din});
        end
        n_checks++;
        if ({busy3, done3, err3, rden3, wren3, rdata3, Address3, Din3} !== 29'd0) begin
            n_fail++;
            $display("FAIL rst_mid_rdwait: got %h expected 0", {busy3, done3, err3, rden3, wren3, rdata3, Address3, Din3});
        end
        tick();
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({busy3, done3, rdata3} !== 10'd0) begin
                n_fail++;
                $display("FAIL rst_no_done[%0d]: got %h expected 0", i, {busy3, done3, rdata3});
            end
        end
    endtask

    task automatic test_timeout();
`ifdef DMEM_TIMEOUT_EN
        ld = 1; addr = 8'h33;
        tick();
        ld = 0;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({busy, rden, err} !== 3'b110) begin
                n_fail++;
                $display("FAIL tmo_wait[%0d]: got %b expected 110", i, {busy, rden, err});
            end
        end
        tick();
        n_checks++;
        if ({busy, rden, err, done, rdata} !== {4'b0010, 8'h00}) begin
            n_fail++;
            $display("FAIL tmo_abort: got %h expected %h", {busy, rden, err, done, rdata}, {4'b0010, 8'h00});
        end
        tick();
        n_checks++;
        if ({err, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL tmo_err_pulse: got %b expected 00", {err, done});
        end
        st = 1; addr = 8'h34; wdata = 8'hC3;
        tick();
        st = 0;
        tick();
        tick();
        tick();
        acq = 1;
        tick();
        acq = 0;
        n_checks++;
        if ({busy, wren, err, done} !== 4'b0001) begin
            n_fail++;
            $display("FAIL tmo_acq_wins: got %b expected 0001", {busy, wren, err, done});
        end
`else
        ld = 1; addr = 8'h33;
        tick();
        ld = 0;
        for (int unsigned i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({busy, rden, err} !== 3'b110) begin
                n_fail++;
                $display("FAIL notmo_wait[%0d]: got %b expected 110", i, {busy, rden, err});
            end
        end
        acq = 1;
        tick();
        acq = 0; Dq = 8'h9B;
        tick();
        n_checks++;
        if ({done, err, rdata} !== {2'b10, 8'h9B}) begin
            n_fail++;
            $display("FAIL notmo_complete: got %h expected %h", {done, err, rdata}, {2'b10, 8'h9B});
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_write_immediate();
        test_read_delayed_grant();
        test_rd_lat3();
        test_back_to_back();
        test_reset_mid_rdwait();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_port.md
Name: dmem_port

Overview:
- Core-side initiator for the shared data-RAM arbiter.
- Converts a single-cycle load/store strobe from a core datapath into the arbiter's request protocol: rden/wren plus Address/Din held until the acq grant.
- Captures read data from the synchronous RAM after a fixed latency and returns a one-cycle done pulse.
- One instance per core, sitting between the core execute stage and its rden/wren/Address/Din/acq/Dq slot on the arbiter.

Parameters:
- RD_LAT, 1, cycles from grant acceptance edge to read-data capture edge; legal 1..7.
- TIMEOUT, 255, max cycles in REQ before abort; used only with DMEM_TIMEOUT_EN; legal 1..255.

Ports:
- CLK  input  1  system clock (divided clock); rising edge
- rst_n  input  1  asynchronous active-low reset
- ld  input  1  core load strobe, sampled in IDLE only
- st  input  1  core store strobe, sampled in IDLE only; wins over ld
- addr  input  8  core access address
- wdata  input  8  core store data
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse when an access completes
- rdata  output  8  last completed load data
- err  output  1  one-cycle timeout pulse; tied 0 without DMEM_TIMEOUT_EN
- rden  output  1  read request to arbiter
- wren  output  1  write request to arbiter
- Address  output  8  latched access address to arbiter
- Din  output  8  latched store data to arbiter
- acq  input  1  arbiter grant for this port
- Dq  input  8  read data from arbiter

Behaviour:
- All outputs are registered. Reset (async on rst_n low) clears everything to 0: state IDLE, busy, done, rdata, err, rden, wren, Address, Din, latency counter, timeout counter.
- IDLE: on a rising edge with st=1:
  - latch addr into Address and wdata into Din;
  - set wren=1;
  - go to REQ.
- IDLE: else on ld=1:
  - latch addr;
  - set rden=1;
  - go to REQ.
- ld and st both high: store only; ld is dropped.
- REQ:
  - rden/wren, Address and Din stay stable every cycle until acq is sampled 1.
  - acq=1 at an edge means accepted. On that edge, clear rden/wren.
  - Write: pulse done on the same edge and return to IDLE. Write latency is 2 cycles minimum (strobe edge, grant edge).
  - Read: load counter with RD_LAT-1 and go to RDWAIT.
- RDWAIT:
  - Counter == 0 at an edge: rdata<=Dq, pulse done, return to IDLE.
  - Otherwise decrement the counter.
  - RD_LAT=1 captures Dq on the edge immediately after the grant edge.
- done is high exactly one cycle. In that cycle the state is already IDLE and busy=0, so a new ld/st in the done cycle is accepted (back-to-back, no bubble).
- ld/st while busy=1 are ignored (no queueing). The core must hold off until busy=0.
- acq while in IDLE or RDWAIT is ignored.
- Address/Din retain their last values in IDLE.
- rdata changes only on read completion. Stores never alter it.
- Reset mid-REQ: request withdrawn immediately (asynchronous).
- Reset mid-RDWAIT: the pending read data is discarded and no done is issued.
- Counters are 3-bit (latency) and 8-bit (timeout). Neither wraps, because both reset on state entry.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - an 8-bit counter clears on entry to REQ and increments each REQ cycle without acq;
  - at count == TIMEOUT-1 without acq: clear rden/wren, pulse err for one cycle, return to IDLE;
  - no done is pulsed and rdata is unchanged.
  - acq and timeout on the same edge: acq wins (normal completion, no err).
- Not defined: no counter logic; err held 0; REQ waits indefinitely for acq.

Test Plan:
- Write, immediate grant:
  - stimulus: st=1, addr=0x12, wdata=0xA5; acq=1 on the first REQ cycle;
  - response: wren high exactly 1 cycle with Address=0x12, Din=0xA5; done one cycle later; busy high 1 cycle.
- Read, RD_LAT=1, grant delayed 3 cycles:
  - stimulus: ld=1, addr=0x40; acq low 3 cycles then high; Dq=0x3C on the cycle after the grant;
  - response: rden high 4 cycles with Address stable at 0x40; rdata=0x3C with done on the next edge.
- RD_LAT=3 read:
  - stimulus: grant at edge E; Dq changes 0x11→0x22→0x33 over the following cycles;
  - response: rdata=0x33, captured at E+3; done at E+3.
- Collision and back-to-back:
  - stimulus: ld=st=1 with addr=0x05; then ld=1 in the done cycle;
  - response: a store issues first; the read is accepted with no idle gap; ld pulses during busy are ignored.
- Reset mid-RDWAIT:
  - stimulus: rst_n low one cycle after the grant;
  - response: all outputs 0 immediately; no done; rdata remains 0 after reset release.
- With DMEM_TIMEOUT_EN, TIMEOUT=4:
  - stimulus: acq held 0;
  - response: rden drops and err pulses after 4 REQ cycles; no done.
  - stimulus: acq=1 on the 4th REQ cycle;
  - response: normal completion, err=0.
